alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised multi-cycle ALU with its own control FSM and a valid/ready handshake on both sides. It succeeds the single-cycle function-select decoder.
- Keeps the same 3-bit FS encodings, extended to 4 bits. Adds XOR, iterative shifting, and an optional iterative multiply.
- Sits between the execute-stage issue logic and the writeback mux. The core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of 2, at least 4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- fs  input  4  function select
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; the shift amount is b[SHW-1:0]
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  operation result
- illegal  output  1  the completed op had an unsupported fs
- busy  output  1  FSM is not in IDLE

Behaviour:
- Function select codes:
  - 0000 ADD, 0001 SUB, 0010 SRA, 0011 SRL, 0100 SLL, 0101 AND, 0110 OR, 0111 XOR.
  - 1000 MUL, only when the feature is enabled.
  - All other codes are illegal.
- Reset (synchronous, on the clk edge while reset=1):
  - state=IDLE, in_ready=1, out_valid=0, result=0, illegal=0, busy=0, internal counter=0.
  - Reset mid-operation abandons the operation and produces no output.
- FSM states: IDLE, SHIFT, MUL, DONE.
- in_ready = (state==IDLE). A request is accepted on a cycle with in_valid && in_ready. fs, a and b are captured that cycle.
- From IDLE on accept:
  - ADD, SUB, AND, OR, XOR, or an illegal code: compute in one cycle, go to DONE.
  - SLL, SRL, SRA with shamt=0: load a into result, go to DONE.
  - SLL, SRL, SRA with shamt>0: load a into result, counter=shamt, go to SHIFT.
  - MUL: go to MUL.
- SHIFT:
  - Shift result by one bit per cycle and decrement counter. Go to DONE when counter reaches 1 on that cycle.
  - SLL fills with 0. SRL fills the MSB with 0. SRA replicates the MSB.
- Arithmetic rules:
  - ADD/SUB results are WIDTH bits, modulo 2^WIDTH, with no carry or overflow output. SUB = a + ~b + 1.
  - Illegal codes: result=0 and illegal=1.
- DONE:
  - out_valid=1. result and illegal are held stable until out_ready=1.
  - On out_valid && out_ready, clear out_valid and go to IDLE. The next accept can occur the cycle after.
- Latency from the accept edge to out_valid high:
  - 1 cycle for single-cycle ops and shamt=0.
  - 1+shamt cycles for shamt>0.
  - WIDTH+1 cycles for MUL.
- Throughput is at most one op per 2 cycles.
- Boundary cases:
  - in_valid while busy is ignored; the requester must hold its request.
  - fs, a and b changing after accept have no effect.
  - out_ready high while out_valid=0 is ignored.
  - shamt=WIDTH-1 is the maximum. Only the low SHW bits of b are used.
- busy=1 in SHIFT, MUL and DONE.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - fs=1000 performs an unsigned shift-add multiply: one bit of b per cycle, LSB first, over WIDTH cycles in MUL.
  - result is the low WIDTH bits of a*b, which is also correct for two's-complement low-half multiply. illegal=0.
- Undefined:
  - The MUL state and its datapath are absent.
  - fs=1000 is illegal: result=0, illegal=1, 1-cycle latency.

Test Plan (WIDTH=32):
- Reset held 2 cycles, then released → in_ready=1, out_valid=0, result=0, busy=0.
- ADD a=0xFFFFFFFF, b=1, out_ready=1 → out_valid exactly 1 cycle after accept, result=0x00000000. SUB a=5, b=7 → result=0xFFFFFFFE.
- SRA a=0x80000000, b=4 → out_valid 5 cycles after accept, result=0xF8000000. SRL with the same operands → 0x08000000. SLL a=1, b=31 → 0x80000000 after 32 cycles. SLL with b=0 → result=1 after 1 cycle.
- Backpressure: XOR a=0xF0F0F0F0, b=0xFF00FF00 with out_ready=0 for 5 cycles → result=0x0FF00FF0 held stable and in_ready=0 throughout. A new in_valid during that window is not accepted.
- Illegal fs=1111 → result=0, illegal=1. With ALU_SEQ_MUL_EN: fs=1000, a=7, b=0xFFFFFFFF → result=0xFFFFFFF9 after 33 cycles. Without the macro, the same request → illegal=1 after 1 cycle.
- Assert reset during a SHIFT with b=20 at cycle 5 → next cycle state is IDLE, out_valid=0, no result emitted. A following ADD 2+3 → 5.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response bundle for the multi-cycle ALU.
// The requester uses master and the ALU uses slave.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       fs;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, fs, a, b, out_ready,
    input  in_ready, out_valid, result, illegal, busy
  );

  modport slave (
    input  in_valid, fs, a, b, out_ready,
    output in_ready, out_valid, result, illegal, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU with a handshake on both sides and iterative shifts.
// Define ALU_SEQ_MUL_EN to add the fs=1000 shift-add multiply.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave io
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef ALU_SEQ_MUL_EN
    MUL   = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ill_q, ill_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
`endif

  logic [SHW-1:0] shamt;
  logic           accept;

  assign shamt  = io.b[SHW-1:0];
  assign accept = io.in_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = io.fs;
          ill_d   = 1'b0;
          state_d = DONE;
          unique case (io.fs)
            4'b0000: res_d = io.a + io.b;
            4'b0001: res_d = io.a + ~io.b + WIDTH'(1);
            4'b0010,
            4'b0011,
            4'b0100: begin
              res_d = io.a;
              cnt_d = shamt;
              if (shamt != '0) state_d = SHIFT;
            end
            4'b0101: res_d = io.a & io.b;
            4'b0110: res_d = io.a | io.b;
            4'b0111: res_d = io.a ^ io.b;
`ifdef ALU_SEQ_MUL_EN
            4'b1000: begin
              res_d    = '0;
              mcand_d  = io.a;
              mplier_d = io.b;
              cnt_d    = '0;
              state_d  = MUL;
            end
`endif
            default: begin
              res_d = '0;
              ill_d = 1'b1;
            end
          endcase
        end
      end
      SHIFT: begin
        unique case (op_q)
          4'b0010: res_d = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
          4'b0011: res_d = {1'b0, res_q[WIDTH-1:1]};
          default: res_d = {res_q[WIDTH-2:0], 1'b0};
        endcase
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_d = DONE;
      end
`ifdef ALU_SEQ_MUL_EN
      // One multiplier bit per cycle, LSB first; counter runs 0..WIDTH-1.
      MUL: begin
        if (mplier_q[0]) res_d = res_q + mcand_q;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == {SHW{1'b1}}) state_d = DONE;
      end
`endif
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.busy      = (state_q != IDLE);
  assign io.result    = res_q;
  assign io.illegal   = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against a behavioural model.
// Build with +define+ALU_SEQ_MUL_EN to cover the multiply.
module tb_alu_seq;
  localparam int W   = 32;
  localparam int SHW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference: {illegal, result} straight from the operation table.
  function automatic logic [W:0] ref_op(input logic [3:0] f,
                                        input logic [W-1:0] x,
                                        input logic [W-1:0] y);
    int sh;
    logic [W-1:0] r;
    logic il;
    sh = int'(y[SHW-1:0]);
    r  = '0;
    il = 1'b0;
    case (f)
      4'd0: r = x + y;
      4'd1: r = x - y;
      4'd2: r = W'($signed(x) >>> sh);
      4'd3: r = x >> sh;
      4'd4: r = x << sh;
      4'd5: r = x & y;
      4'd6: r = x | y;
      4'd7: r = x ^ y;
`ifdef ALU_SEQ_MUL_EN
      4'd8: r = x * y;
`endif
      default: il = 1'b1;
    endcase
    return {il, r};
  endfunction

  function automatic int ref_lat(input logic [3:0] f,
                                 input logic [W-1:0] y);
    int sh;
    sh = int'(y[SHW-1:0]);
    if (f == 4'd2 || f == 4'd3 || f == 4'd4)
      return (sh == 0) ? 1 : 1 + sh;
`ifdef ALU_SEQ_MUL_EN
    if (f == 4'd8) return W + 1;
`endif
    return 1;
  endfunction

  // Compare process: model one outstanding op, check every cycle.
  bit           pend = 1'b0;
  bit           en = 1'b0;
  int           due = 0;
  logic [W:0]   exp_v = '0;

  always @(negedge clk) begin
    bit ev;
    ev = pend && (cyc >= due);
    if (en) begin
      chk("out_valid", bus.out_valid, ev);
      chk("in_ready", bus.in_ready, !pend);
      chk("busy", bus.busy, pend);
      if (ev) begin
        chk("result", bus.result, exp_v[W-1:0]);
        chk("illegal", bus.illegal, exp_v[W]);
      end
    end
    if (reset) begin
      pend = 1'b0;
      en   = 1'b1;
    end else if (!pend && bus.in_valid) begin
      pend  = 1'b1;
      exp_v = ref_op(bus.fs, bus.a, bus.b);
      due   = cyc + ref_lat(bus.fs, bus.b);
    end else if (ev && bus.out_ready) begin
      pend = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] f,
                     input logic [W-1:0] x,
                     input logic [W-1:0] y,
                     input int hold,
                     input bit early,
                     input bit lit,
                     input logic [W-1:0] er,
                     input bit ei,
                     input int el);
    int n;
    int acc;
    bus.fs = f;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    bus.out_ready = early;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    if (!bus.in_ready) begin
      fail("accept_timeout");
      bus.in_valid = 1'b0;
      return;
    end
    acc = cyc;
    step();
    bus.in_valid = 1'b0;
    bus.fs = 4'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
    if (!bus.out_valid) begin
      fail("out_valid_timeout");
      bus.out_ready = 1'b0;
      return;
    end
    if (lit) begin
      chk("lit_latency", 64'(cyc - acc), 64'(el));
      chk("lit_result", bus.result, er);
      chk("lit_illegal", bus.illegal, ei);
    end
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = 1'b1;
        chk("bp_in_ready", bus.in_ready, 1'b0);
        if (lit) chk("bp_hold", bus.result, er);
        step();
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.fs = '0;
    bus.a = '0;
    bus.b = '0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, '0);
    chk("rst_busy", bus.busy, 1'b0);

    run(4'd0, 32'hFFFF_FFFF, 32'd1, 0, 1, 1, 32'h0000_0000, 0, 1);
    run(4'd1, 32'd5, 32'd7, 0, 0, 1, 32'hFFFF_FFFE, 0, 1);
    run(4'd2, 32'h8000_0000, 32'd4, 0, 0, 1, 32'hF800_0000, 0, 5);
    run(4'd3, 32'h8000_0000, 32'd4, 0, 0, 1, 32'h0800_0000, 0, 5);
    run(4'd4, 32'd1, 32'd31, 0, 0, 1, 32'h8000_0000, 0, 32);
    run(4'd4, 32'd1, 32'd0, 0, 0, 1, 32'h0000_0001, 0, 1);
    run(4'd2, 32'h8000_0001, 32'hFFFF_FFE3, 0, 0, 1, 32'hF000_0000, 0, 4);
    run(4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 5, 0, 1,
        32'h0FF0_0FF0, 0, 1);
    run(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 1, 32'h0, 1, 1);
`ifdef ALU_SEQ_MUL_EN
    run(4'd8, 32'd7, 32'hFFFF_FFFF, 0, 0, 1, 32'hFFFF_FFF9, 0, 33);
`else
    run(4'd8, 32'd7, 32'hFFFF_FFFF, 0, 0, 1, 32'h0, 1, 1);
`endif

    // Abandon a long shift with reset.
    bus.fs = 4'd4;
    bus.a = 32'h0000_0003;
    bus.b = 32'd20;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("mid_busy", bus.busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_in_ready", bus.in_ready, 1'b1);
    chk("abort_result", bus.result, '0);
    repeat (25) begin
      chk("abort_no_output", bus.out_valid, 1'b0);
      step();
    end
    run(4'd0, 32'd2, 32'd3, 0, 0, 1, 32'd5, 0, 1);

    for (int k = 0; k < 60; k++) begin
      logic [3:0] f;
      int hold;
      bit early;
      f = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      early = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      run(f, $urandom, $urandom, hold, early, 0, '0, 0, 0);
      bus.out_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) step();
      bus.out_ready = 1'b0;
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
